// File: rtl/mod_n_count_checker.sv
// Sequence monitor for a mod-N up-counter. It locks onto the increment
// sequence on qualified samples, then flags and counts deviations and counts
// wraps.
module mod_n_count_checker #(
    parameter int WIDTH      = 8,
    parameter int MODULUS    = 8,
    parameter int LOCK_COUNT = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] q,
    input  logic             clear_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] expected
);

    // One extra bit so that MODULUS == 2**WIDTH still fits as a comparison bound.
    localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MODULUS - 1);
    localparam int             MC_W  = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    // Match count value at which the next correct increment completes the lock.
    localparam logic [MC_W-1:0] LOCK_LAST = MC_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        UNSYNC  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
    logic             err_pulse_q, err_pulse_d;
    logic             wrap_pulse_q, wrap_pulse_d;

    logic             q_in_range;
    logic [WIDTH-1:0] q_next;
    logic             err_hit;
    logic             wrap_hit;

    // Range check and successor of the current sample.
    always_comb begin
        q_in_range = ({1'b0, q} <= MAX_V);
        if ({1'b0, q} == MAX_V) begin
            q_next = '0;
        end else begin
            q_next = q + 1'b1;
        end
    end

    // Next-state logic for the lock FSM; only qualified samples move it.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        expected_d  = expected_q;
        err_hit     = 1'b0;
        wrap_hit    = 1'b0;
        if (en) begin
            case (state_q)
                UNSYNC: begin
                    if (q_in_range) begin
                        expected_d  = q_next;
                        match_cnt_d = '0;
                        state_d     = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (!q_in_range) begin
                        match_cnt_d = '0;
                        state_d     = UNSYNC;
                    end else if (q == expected_q) begin
                        expected_d = q_next;
                        if (match_cnt_q == LOCK_LAST) begin
                            match_cnt_d = '0;
                            state_d     = LOCKED;
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else begin
                        // Different but plausible value: restart acquisition from it.
                        expected_d  = q_next;
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (q_in_range && (q == expected_q)) begin
                        expected_d = q_next;
                        wrap_hit   = (q == '0);
                    end else begin
                        err_hit     = 1'b1;
                        match_cnt_d = '0;
                        if (q_in_range) begin
                            expected_d = q_next;
                            state_d    = ACQUIRE;
                        end else begin
                            state_d = UNSYNC;
                        end
                    end
                end
                default: begin
                    state_d     = UNSYNC;
                    match_cnt_d = '0;
                end
            endcase
        end
    end

    // Counters and pulses; a clear that coincides with an error leaves one error.
    always_comb begin
        err_pulse_d  = err_hit;
        wrap_pulse_d = wrap_hit;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        if (clear_err) begin
            err_count_d = CNT_W'(err_hit);
        end else if (err_hit && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
        if (wrap_hit) begin
            wrap_count_d = wrap_count_q + 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= UNSYNC;
            match_cnt_q  <= '0;
            expected_q   <= '0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_cnt_q  <= match_cnt_d;
            expected_q   <= expected_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    assign locked     = (state_q == LOCKED);
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign expected   = expected_q;

endmodule

// File: tb/tb_mod_n_count_checker.sv
// Bench for mod_n_count_checker: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model. A second
// instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_mod_n_count_checker;

    localparam int M    = 8;
    localparam int LOCK = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] q;
    logic       clear_err;

    logic       locked_a, err_pulse_a, wrap_pulse_a;
    logic [7:0] err_count_a, wrap_count_a, expected_a;
    logic       locked_b, err_pulse_b, wrap_pulse_b;
    logic [1:0] err_count_b, wrap_count_b;
    logic [7:0] expected_b;

    int n_chk = 0;
    int n_err = 0;
    int n_txn = 0;

    always #5 clk = ~clk;

    mod_n_count_checker #(.WIDTH(8), .MODULUS(M), .LOCK_COUNT(LOCK), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .q(q), .clear_err(clear_err),
        .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a),
        .wrap_pulse(wrap_pulse_a), .wrap_count(wrap_count_a), .expected(expected_a)
    );

    mod_n_count_checker #(.WIDTH(8), .MODULUS(M), .LOCK_COUNT(LOCK), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .en(en), .q(q), .clear_err(clear_err),
        .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b),
        .wrap_pulse(wrap_pulse_b), .wrap_count(wrap_count_b), .expected(expected_b)
    );

    // Behavioural model: a reference value plus a run length of good increments.
    bit m_have, m_lk, m_errp, m_wrapp;
    int m_run, m_exp, m_err8, m_err2, m_wrap;

    task automatic model_step(input bit rst_n, input bit e, input int qv, input bit clr);
        bit inr, ev;
        int nxt;
        m_errp  = 1'b0;
        m_wrapp = 1'b0;
        ev      = 1'b0;
        if (!rst_n) begin
            m_have = 0; m_lk = 0; m_run = 0; m_exp = 0;
            m_err8 = 0; m_err2 = 0; m_wrap = 0;
            return;
        end
        if (e) begin
            inr = (qv < M);
            nxt = (qv + 1) % M;
            if (m_lk) begin
                if (inr && qv == m_exp) begin
                    m_exp = nxt;
                    if (qv == 0) begin
                        m_wrapp = 1'b1;
                        m_wrap  = m_wrap + 1;
                    end
                end else begin
                    ev = 1'b1; m_errp = 1'b1; m_lk = 0; m_run = 0;
                    m_have = inr;
                    if (inr) m_exp = nxt;
                end
            end else if (!inr) begin
                m_have = 0; m_run = 0;
            end else if (m_have && qv == m_exp) begin
                m_run = m_run + 1;
                m_exp = nxt;
                if (m_run >= LOCK) m_lk = 1;
            end else begin
                m_have = 1; m_run = 0; m_exp = nxt;
            end
        end
        if (clr) begin
            m_err8 = ev ? 1 : 0;
            m_err2 = ev ? 1 : 0;
        end else if (ev) begin
            if (m_err8 < 255) m_err8 = m_err8 + 1;
            if (m_err2 < 3)   m_err2 = m_err2 + 1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic check_model();
        chk("locked",       int'(locked_a),     int'(m_lk));
        chk("err_pulse",    int'(err_pulse_a),  int'(m_errp));
        chk("wrap_pulse",   int'(wrap_pulse_a), int'(m_wrapp));
        chk("err_count",    int'(err_count_a),  m_err8);
        chk("wrap_count",   int'(wrap_count_a), m_wrap % 256);
        chk("expected",     int'(expected_a),   m_exp);
        chk("b_err_count",  int'(err_count_b),  m_err2);
        chk("b_wrap_count", int'(wrap_count_b), m_wrap % 4);
        chk("b_locked",     int'(locked_b),     int'(m_lk));
    endtask

    // Inputs change at the falling edge; outputs are checked at the next falling edge.
    task automatic cycle(input bit rst_n, input bit e, input int qv, input bit clr);
        reset     = rst_n;
        en        = e;
        q         = 8'(qv);
        clear_err = clr;
        @(posedge clk);
        model_step(rst_n, e, qv, clr);
        @(negedge clk);
        n_txn++;
        $display("txn %0d reset=%0b en=%0b q=%0d clr=%0b -> locked=%0b errp=%0b wrapp=%0b errc=%0d wrapc=%0d exp=%0d",
                 n_txn, rst_n, e, qv, clr, locked_a, err_pulse_a, wrap_pulse_a,
                 err_count_a, wrap_count_a, expected_a);
        check_model();
    endtask

    // Three consecutive values from v; reaches lock from any unlocked state.
    task automatic lock_at(input int v);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, (v + i) % M, 1'b0);
    endtask

    typedef struct {
        bit rst_n; bit e; int qv; bit clr;
        bit x_locked; bit x_errp; bit x_wrapp; int x_errc; int x_wrapc; int x_exp;
    } vec_t;

    vec_t vt[15];

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            cycle(vt[i].rst_n, vt[i].e, vt[i].qv, vt[i].clr);
            chk($sformatf("vec%0d_locked", i),     int'(locked_a),     int'(vt[i].x_locked));
            chk($sformatf("vec%0d_err_pulse", i),  int'(err_pulse_a),  int'(vt[i].x_errp));
            chk($sformatf("vec%0d_wrap_pulse", i), int'(wrap_pulse_a), int'(vt[i].x_wrapp));
            chk($sformatf("vec%0d_err_count", i),  int'(err_count_a),  vt[i].x_errc);
            chk($sformatf("vec%0d_wrap_count", i), int'(wrap_count_a), vt[i].x_wrapc);
            chk($sformatf("vec%0d_expected", i),   int'(expected_a),   vt[i].x_exp);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; q = '0; clear_err = 1'b0;
        m_have = 0; m_lk = 0; m_run = 0; m_exp = 0; m_err8 = 0; m_err2 = 0; m_wrap = 0;
        m_errp = 0; m_wrapp = 0;

        //        rst en q  clr  lk ep wp ec wc exp
        vt[0]  = '{0, 1, 3, 0,   0, 0, 0, 0, 0, 0};   // reset beats en
        vt[1]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        vt[2]  = '{1, 1, 3, 0,   0, 0, 0, 0, 0, 4};   // acquire
        vt[3]  = '{1, 1, 4, 0,   0, 0, 0, 0, 0, 5};
        vt[4]  = '{1, 1, 5, 0,   1, 0, 0, 0, 0, 6};   // locked after q=5
        vt[5]  = '{1, 1, 6, 0,   1, 0, 0, 0, 0, 7};
        vt[6]  = '{1, 1, 7, 0,   1, 0, 0, 0, 0, 0};
        vt[7]  = '{1, 1, 0, 0,   1, 0, 1, 0, 1, 1};   // wrap
        vt[8]  = '{1, 1, 1, 0,   1, 0, 0, 0, 1, 2};
        vt[9]  = '{1, 1, 5, 0,   0, 1, 0, 1, 4, 6};   // error after 3 more wraps
        vt[10] = '{1, 1, 6, 0,   0, 0, 0, 1, 4, 7};
        vt[11] = '{1, 1, 7, 0,   1, 0, 0, 1, 4, 0};   // relocked
        vt[12] = '{1, 1, 0, 0,   1, 0, 1, 1, 5, 1};
        vt[13] = '{1, 1, 1, 0,   1, 0, 0, 1, 5, 2};
        vt[14] = '{1, 1, 1, 0,   0, 1, 0, 2, 5, 2};   // held value is an error

        @(negedge clk);
        run_rows(0, 8);
        // Three more full periods while locked.
        for (int i = 0; i < 24; i++) cycle(1'b1, 1'b1, (2 + i) % M, 1'b0);
        chk("wrap_count_after_24", int'(wrap_count_a), 4);
        run_rows(9, 14);

        // Out of range while locked, then en=0 gating.
        lock_at(2);                                   // ACQUIRE resync -> locked, exp 5
        cycle(1'b1, 1'b1, 9, 1'b0);
        chk("oor_err_pulse", int'(err_pulse_a), 1);
        chk("oor_locked",    int'(locked_a),    0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, int'($urandom_range(0, 255)), 1'b0);
            chk("gated_err_pulse", int'(err_pulse_a), 0);
            chk("gated_expected",  int'(expected_a),  5);
        end
        cycle(1'b1, 1'b1, 2, 1'b0);
        chk("reacq_expected", int'(expected_a), 3);
        chk("reacq_locked",   int'(locked_a),   0);

        // Saturation of the 2-bit error counter and clear interactions.
        for (int k = 0; k < 5; k++) begin
            lock_at(k);
            cycle(1'b1, 1'b1, (m_exp + 3) % M, 1'b0);
        end
        chk("sat_b_err_count", int'(err_count_b), 3);
        lock_at(0);
        cycle(1'b1, 1'b1, 6, 1'b1);
        chk("clr_err_b", int'(err_count_b), 1);
        chk("clr_err_a", int'(err_count_a), 1);
        chk("clr_err_pulse", int'(err_pulse_a), 1);
        cycle(1'b1, 1'b0, 0, 1'b1);
        chk("clr_only_a", int'(err_count_a), 0);
        chk("clr_only_b", int'(err_count_b), 0);
        chk("clr_wrap_kept", int'(wrap_count_a), 5);

        // Reset mid-lock.
        cycle(1'b0, 1'b0, 0, 1'b0);
        lock_at(5);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, i % M, 1'b0);
        chk("pre_reset_wraps", int'(wrap_count_a), 2);
        cycle(1'b0, 1'b1, 1, 1'b0);
        chk("rst_locked",     int'(locked_a),     0);
        chk("rst_wrap_count", int'(wrap_count_a), 0);
        chk("rst_expected",   int'(expected_a),   0);
        cycle(1'b1, 1'b1, 0, 1'b0);
        chk("post_rst_no_wrap", int'(wrap_pulse_a), 0);
        chk("post_rst_exp",     int'(expected_a),   1);

        // Randomized run, mostly following the sequence.
        for (int i = 0; i < 400; i++) begin
            int  qv;
            bit  e, clr, rn;
            rn  = ($urandom_range(0, 99) != 0);
            e   = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) < 8) qv = m_exp;
            else                           qv = int'($urandom_range(0, 15));
            cycle(rn, e, qv, clr);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
